d_bju: RTL
==========

D_BJU -- requirements
Module: D_BJU

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 The block SHALL have the port Stall, input, 1 bit: when 1, all state holds; D-stage inputs are re-presented next cycle.
REQ-004 The block SHALL have the port ACmpB, input, 2 bits: D-stage compare of rs against rt; 00 equal, 01 greater, 10 less, 11 invalid.
REQ-005 The block SHALL have the port ACmp0, input, 2 bits: D-stage compare of rs against zero; same encoding as ACmpB.
REQ-006 The block SHALL have the port BrOp, input, 3 bits: 000 none, 001 beq, 010 bne, 011 blez, 100 bgtz, 101 bltz, 110 bgez, 111 reserved (treated as none).
REQ-007 The block SHALL have the port JOp, input, 2 bits: 00 none, 01 j, 10 jal, 11 jr.
REQ-008 The block SHALL have the port PC_D, input, 32 bits: PC of the instruction in D.
REQ-009 The block SHALL have the port Imm16, input, 16 bits: branch offset.
REQ-010 The block SHALL have the port Index26, input, 26 bits: jump index.
REQ-011 The block SHALL have the port RsVal, input, 32 bits: forwarded rs value, used as the jr target.
REQ-012 The block SHALL have the port PC_F, output, 32 bits: registered fetch PC.
REQ-013 The block SHALL have the port Taken_D, output, 1 bit: combinational redirect decision for the current D instruction.
REQ-014 The block SHALL have the port InSlot_D, output, 1 bit: the D instruction is a delay slot.
REQ-015 The block SHALL have the port TakenCnt, output, 32 bits: count of committed redirects.
REQ-016 The block SHALL have the port Err, output, 1 bit: sticky error flag.

Function
REQ-017 Branch condition SHALL decode as follows:
- beq: ACmpB==00
- bne: ACmpB!=00
- blez: ACmp0 in {00,10}
- bgtz: ACmp0==01
- bltz: ACmp0==10
- bgez: ACmp0 in {00,01}
REQ-018 A code of 11 on the compare input a branch selects SHALL force the branch not-taken and SHALL set Err.
REQ-019 A nonzero JOp SHALL take precedence over BrOp, with Taken_D=1 unconditionally.
REQ-020 Targets SHALL be computed as follows:
- branch: PC_D+4+(sign-extended Imm16<<2), modulo 2^32 with no overflow detection
- j/jal: {PC_D[31:28],Index26,2'b00}
- jr: {RsVal[31:2],2'b00}
REQ-021 A jr whose RsVal[1:0]!=00 SHALL redirect to the aligned target and SHALL set Err.
REQ-022 When Stall=0, on each clk edge PC_F SHALL load the target if Taken_D=1, otherwise PC_F+4 (wrapping at 2^32); the redirect takes effect with one-cycle latency, and the delay slot already in F is not squashed.
REQ-023 When Stall=1, PC_F, the FSM, TakenCnt and Err SHALL hold, and Taken_D SHALL still reflect the current inputs.
REQ-024 The slot FSM SHALL have two states, RUN and SLOT:
- RUN -> SLOT on an unstalled edge with Taken_D=1
- SLOT -> RUN on any unstalled edge
- InSlot_D=1 exactly in SLOT.
REQ-025 A branch or jump in D while in SLOT SHALL force Taken_D=0 and SHALL set Err; the FSM then returns to RUN.
REQ-026 TakenCnt SHALL increment on each unstalled edge with Taken_D=1, saturating at 0xFFFFFFFF.
REQ-027 Err SHALL clear only on reset.

Reset
REQ-028 Asserting reset SHALL immediately force:
- PC_F=0x00003000
- FSM=RUN
- TakenCnt=0
- Err=0
REQ-029 Reset asserted mid-redirect or mid-stall SHALL discard the pending target, and the first unstalled edge after deassertion SHALL load 0x00003004.

Structure
REQ-030 BrOp/JOp encodings, compare codes, the reset PC value and the FSM state codes SHALL reside in the shared CPU definitions file.
REQ-031 Condition decode SHALL be a combinational sub-module D_BCOND (BrOp, ACmpB, ACmp0 -> cond, badcode).

Verification
REQ-032 Reset, then 3 unstalled cycles SHALL produce PC_F sequence 0x3000, 0x3004, 0x3008, 0x300C.
REQ-033 PC_D=0x3010, BrOp=beq, ACmpB=00, Imm16=0xFFFC SHALL give Taken_D=1, next PC_F=0x3004, InSlot_D=1 for one cycle and TakenCnt=1.
REQ-034 BrOp=bgez with ACmp0=10 SHALL give Taken_D=0 and PC_F+4, while BrOp=blez with ACmp0=11 SHALL give Taken_D=0 and Err=1.
REQ-035 JOp=jr, RsVal=0x00003042 SHALL give next PC_F=0x00003040 and Err=1.
REQ-036 A taken branch with Stall=1 for 2 cycles SHALL hold PC_F and TakenCnt for 2 cycles and redirect on the first unstalled edge.
REQ-037 A branch in the delay slot SHALL give Taken_D=0, Err=1 and the FSM back in RUN; asserting reset mid-SLOT SHALL restore PC_F=0x3000 with InSlot_D=0.

Source files
------------

// File: rtl/d_bju_pkg.sv
// d_bju_pkg: shared CPU definitions for branch/jump decode, compare codes, reset PC and slot FSM.
package d_bju_pkg;
  typedef enum logic [2:0] {BR_NONE, BR_BEQ, BR_BNE, BR_BLEZ, BR_BGTZ, BR_BLTZ, BR_BGEZ, BR_RSVD} brop_t;
  typedef enum logic [1:0] {J_NONE, J_J, J_JAL, J_JR} jop_t;
  typedef enum logic [1:0] {CMP_EQ, CMP_GT, CMP_LT, CMP_BAD} cmp_t;
  typedef enum logic {RUN, SLOT} state_t;
  localparam logic [31:0] RESET_PC = 32'h0000_3000;
endpackage

// File: rtl/d_bcond.sv
// d_bcond: combinational branch-condition decode from the D-stage compare results.
module d_bcond import d_bju_pkg::*; (
  input  logic [2:0] BrOp,
  input  logic [1:0] ACmpB,
  input  logic [1:0] ACmp0,
  output logic       cond,
  output logic       badcode
);
  brop_t op;
  cmp_t c;
  logic raw, is_br;
  assign op = brop_t'(BrOp);
  assign c = cmp_t'((op == BR_BEQ || op == BR_BNE) ? ACmpB : ACmp0);
  assign is_br = op != BR_NONE && op != BR_RSVD;
  always_comb begin
    case (op)
      BR_BEQ:  raw = c == CMP_EQ;
      BR_BNE:  raw = c != CMP_EQ;
      BR_BLEZ: raw = c == CMP_EQ || c == CMP_LT;
      BR_BGTZ: raw = c == CMP_GT;
      BR_BLTZ: raw = c == CMP_LT;
      BR_BGEZ: raw = c == CMP_EQ || c == CMP_GT;
      default: raw = 1'b0;
    endcase
  end
  assign badcode = is_br && c == CMP_BAD;
  assign cond = raw && !badcode;
endmodule

// File: rtl/d_bju.sv
// d_bju: D-stage branch/jump unit owning the fetch PC, delay-slot tracking, redirect count and error flag.
module d_bju import d_bju_pkg::*; (
  input  logic        clk,
  input  logic        reset,
  input  logic        Stall,
  input  logic [1:0]  ACmpB,
  input  logic [1:0]  ACmp0,
  input  logic [2:0]  BrOp,
  input  logic [1:0]  JOp,
  input  logic [31:0] PC_D,
  input  logic [15:0] Imm16,
  input  logic [25:0] Index26,
  input  logic [31:0] RsVal,
  output logic [31:0] PC_F,
  output logic        Taken_D,
  output logic        InSlot_D,
  output logic [31:0] TakenCnt,
  output logic        Err
);
  state_t state, state_nxt;
  jop_t jop;
  brop_t bop;
  logic cond, badcode, is_j, is_br, jr_mis, err_set;
  logic [31:0] target;
  d_bcond u_bcond (.BrOp(BrOp), .ACmpB(ACmpB), .ACmp0(ACmp0), .cond(cond), .badcode(badcode));
  assign jop = jop_t'(JOp);
  assign bop = brop_t'(BrOp);
  assign is_j = jop != J_NONE;
  assign is_br = bop != BR_NONE && bop != BR_RSVD;
  assign jr_mis = jop == J_JR && RsVal[1:0] != 2'b00;
  assign target = jop == J_JR ? {RsVal[31:2], 2'b00}
                : is_j      ? {PC_D[31:28], Index26, 2'b00}
                : PC_D + 32'd4 + {{14{Imm16[15]}}, Imm16, 2'b00};
  // A control transfer sitting in the delay slot is suppressed and flagged.
  assign err_set = InSlot_D ? (is_j || is_br) : (is_j ? jr_mis : badcode);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= RUN;
    else state <= state_nxt;
  end
  always_comb state_nxt = Stall ? state : (Taken_D ? SLOT : RUN);
  always_comb begin
    InSlot_D = state == SLOT;
    Taken_D = !InSlot_D && (is_j || cond);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      PC_F <= RESET_PC;
      TakenCnt <= '0;
      Err <= 1'b0;
    end else if (!Stall) begin
      PC_F <= Taken_D ? target : PC_F + 32'd4;
      TakenCnt <= TakenCnt + {31'd0, Taken_D && TakenCnt != 32'hFFFF_FFFF};
      Err <= Err | err_set;
    end
  end
endmodule
